x_byte_seq: RTL and testbench
=============================

Name: x_byte_seq

Overview:
- Sequencer that programs the 64-bit byte-command deserializer of the delay-line configuration path.
- Accepts a complete 64-bit target configuration over a valid/ready request port.
- Emits the minimal stream of 8-bit bit-write commands (only bits that differ from a local shadow copy), then one apply command.
- Sits between the host command decoder (or UART RX framing) and the deserializer's i_valid/i_cmd inputs.

Parameters:
- GAP, 0, idle cycles inserted after each accepted command before the next o_valid (pacing for slow consumers); range 0..255.
- APPLY_OP, 7'h00, op field (bits 6:0) placed in the apply command.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_req_valid  input  1  target word valid
- o_req_ready  output  1  sequencer can accept a target word
- i_req_data  input  64  target configuration word
- o_valid  output  1  command valid toward deserializer
- o_cmd  output  8  command byte
- i_cmd_ready  input  1  consumer accepts o_cmd this cycle (tie high for a direct connection)
- o_busy  output  1  sequence in progress
- o_done  output  1  one-cycle pulse when the apply command is accepted

Behaviour:
- Command encoding:
  - write = {1'b1, data, index[5:0]}
  - apply = {1'b0, APPLY_OP}
- Reset values: o_req_ready=0 while i_rst is high, then 1 in IDLE; o_valid=0, o_cmd=0, o_busy=0, o_done=0.
- Internal reset values: shadow=0 (matches the deserializer reset value), target=0, idx=0, gap counter=0, state=IDLE.
- States: IDLE, SCAN, WRITE, APPLY, GAP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid & o_req_ready: latch i_req_data into target, idx<=0, go SCAN.
- SCAN (one bit per cycle):
  - If target[idx] != shadow[idx], go WRITE.
  - Else if idx==63, go APPLY.
  - Else idx<=idx+1.
- WRITE:
  - o_valid=1, o_cmd={1,target[idx],idx}.
  - o_valid and o_cmd are held stable until i_cmd_ready.
  - On handshake: shadow[idx]<=target[idx]. If idx==63, next is APPLY, else idx<=idx+1 and next is SCAN. The next state is routed through GAP when GAP>0.
- APPLY:
  - o_valid=1, o_cmd={0,APPLY_OP}, held until i_cmd_ready.
  - On handshake: o_done=1 for one cycle, then IDLE (via GAP when GAP>0).
- GAP:
  - o_valid=0 for exactly GAP cycles, then enters the saved next state.
- o_valid is registered; it never drops without a handshake and never changes o_cmd while waiting.
- o_busy=1 in every state except IDLE.
- Latency, no differing bits, GAP=0, i_cmd_ready=1:
  - request accepted at edge 0
  - SCAN occupies cycles 1..64
  - apply command valid in cycle 65
  - o_done in cycle 66
  - o_req_ready back in cycle 66
- Each differing bit adds one WRITE cycle plus GAP cycles.
- Same target twice: the second sequence emits only the apply command.
- i_req_valid outside IDLE is ignored; the requester must hold it until o_req_ready.
- i_cmd_ready outside WRITE/APPLY has no effect.
- Reset mid-sequence:
  - All state clears immediately and asynchronously; o_valid drops.
  - Any partially written bits are lost from the shadow. This is correct only if the deserializer shares the same reset; the system guarantees this.

Optional Feature:
- Macro X_BYTE_SEQ_FULL_WRITE_EN.
- Defined:
  - SCAN treats every bit as differing; all 64 write commands are emitted in index order 0..63, then apply.
  - The shadow still updates.
  - Used for resynchronisation when the deserializer may have been reset independently.
- Undefined: differential writes only, as described above.

Test Plan:
- Reset, then request 64'h0 with GAP=0, i_cmd_ready=1 -> no write commands; apply 8'h00 in cycle 65; o_done pulse; shadow stays 0.
- Request 64'h8000_0000_0000_0005 -> commands 8'hC0 (bit0=1), 8'hC2 (bit2=1), 8'hFF (bit63=1), then 8'h00, in that order; o_done once.
- Same word again, then 64'h1 -> second request: apply only; third request: 8'h82 (bit2=0), 8'hBF (bit63=0), apply.
- i_cmd_ready toggling pseudo-randomly, GAP=3 -> o_cmd stable while o_valid && !i_cmd_ready; exactly 3 idle cycles between accepted commands; command count equals popcount of the XOR plus one.
- Assert i_rst during the second write of 64'hF -> o_valid low immediately, o_req_ready=1 after release; re-request 64'hF emits writes for bits 0..3.
- With X_BYTE_SEQ_FULL_WRITE_EN defined, request 64'hA -> 64 write commands with data bits matching 64'hA, then apply.

Source files
------------

// File: rtl/x_byte_seq_if.sv
// rtl/x_byte_seq_if.sv - request and command handshake bundle for x_byte_seq
interface x_byte_seq_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [63:0] i_req_data;
   logic        o_valid;
   logic [7:0]  o_cmd;
   logic        i_cmd_ready;
   logic        o_busy;
   logic        o_done;

   modport master (
      output i_req_valid, i_req_data, i_cmd_ready,
      input  o_req_ready, o_valid, o_cmd, o_busy, o_done
   );

   modport slave (
      input  i_req_valid, i_req_data, i_cmd_ready,
      output o_req_ready, o_valid, o_cmd, o_busy, o_done
   );
endinterface

// File: rtl/x_byte_seq.sv
// rtl/x_byte_seq.sv - differential bit-write command sequencer for the 64-bit byte-command deserializer
// Optional X_BYTE_SEQ_FULL_WRITE_EN: rewrite all 64 bits on every request (resynchronisation).
module x_byte_seq #(
   parameter int unsigned GAP      = 0,
   parameter logic [6:0]  APPLY_OP = 7'h00
) (
   input  logic          i_clk,
   input  logic          i_rst,
   x_byte_seq_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_WRITE,
      S_APPLY,
      S_GAP
   } state_t;

   localparam logic        GAP_EN    = (GAP != 0);
   localparam int unsigned GAP_M1    = (GAP != 0) ? GAP - 1 : 0;
   localparam logic [7:0]  GAP_LOAD  = GAP_M1[7:0];
   localparam logic [7:0]  APPLY_CMD = {1'b0, APPLY_OP};

   state_t      state_q;
   state_t      ret_q;
   logic [63:0] target_q;
   logic [63:0] shadow_q;
   logic [5:0]  idx_q;
   logic [7:0]  gap_q;
   logic        valid_q;
   logic [7:0]  cmd_q;
   logic        done_q;
   logic        ready_q;
   logic        busy_q;

   logic        bit_diff_d;
   logic        last_idx_d;
   logic        cmd_hs_d;
   state_t      write_next_d;

   always_comb begin
`ifdef X_BYTE_SEQ_FULL_WRITE_EN
      bit_diff_d = 1'b1;
`else
      bit_diff_d = target_q[idx_q] ^ shadow_q[idx_q];
`endif
      last_idx_d   = (idx_q == 6'd63);
      cmd_hs_d     = valid_q & bus.i_cmd_ready;
      write_next_d = last_idx_d ? S_APPLY : S_SCAN;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         ret_q    <= S_IDLE;
         target_q <= '0;
         shadow_q <= '0;
         idx_q    <= '0;
         gap_q    <= '0;
         valid_q  <= 1'b0;
         cmd_q    <= '0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (bus.i_req_valid && ready_q) begin
                  target_q <= bus.i_req_data;
                  idx_q    <= '0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (bit_diff_d) begin
                  state_q <= S_WRITE;
                  valid_q <= 1'b1;
                  cmd_q   <= {1'b1, target_q[idx_q], idx_q};
               end else if (last_idx_d) begin
                  state_q <= S_APPLY;
                  valid_q <= 1'b1;
                  cmd_q   <= APPLY_CMD;
               end else begin
                  idx_q <= idx_q + 6'd1;
               end
            end

            S_WRITE: begin
               if (cmd_hs_d) begin
                  valid_q         <= 1'b0;
                  shadow_q[idx_q] <= target_q[idx_q];
                  if (!last_idx_d) begin
                     idx_q <= idx_q + 6'd1;
                  end
                  if (GAP_EN) begin
                     state_q <= S_GAP;
                     ret_q   <= write_next_d;
                     gap_q   <= GAP_LOAD;
                  end else if (last_idx_d) begin
                     state_q <= S_APPLY;
                     valid_q <= 1'b1;
                     cmd_q   <= APPLY_CMD;
                  end else begin
                     state_q <= S_SCAN;
                  end
               end
            end

            S_APPLY: begin
               if (cmd_hs_d) begin
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                  if (GAP_EN) begin
                     state_q <= S_GAP;
                     ret_q   <= S_IDLE;
                     gap_q   <= GAP_LOAD;
                  end else begin
                     state_q <= S_IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end

            S_GAP: begin
               // gap_q counts down GAP-1..0, so this state lasts exactly GAP cycles
               if (gap_q != 8'd0) begin
                  gap_q <= gap_q - 8'd1;
               end else begin
                  state_q <= ret_q;
                  case (ret_q)
                     S_APPLY: begin
                        valid_q <= 1'b1;
                        cmd_q   <= APPLY_CMD;
                     end
                     S_IDLE: begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end

            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_req_ready = ready_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_cmd       = cmd_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;

endmodule

// File: tb/tb_x_byte_seq.sv
// tb/tb_x_byte_seq.sv - directed table-driven bench for x_byte_seq (GAP=0 and GAP=3 instances)
module tb_x_byte_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   x_byte_seq_if bus0 ();
   x_byte_seq_if bus3 ();

   x_byte_seq #(.GAP(0), .APPLY_OP(7'h00)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
   x_byte_seq #(.GAP(3), .APPLY_OP(7'h00)) dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int acc0  = 0;
   logic rnd3 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor for the GAP=0 instance
   logic [7:0] q0[$];
   int         q0_rel[$];
   int         done0_cnt = 0;
   int         done0_rel = 0;
   logic       ready_at_done0 = 1'b0;
   always @(negedge clk) begin
      if (!rst && bus0.o_valid && bus0.i_cmd_ready) begin
         q0.push_back(bus0.o_cmd);
         q0_rel.push_back(cyc - acc0 + 1);
      end
      if (bus0.o_done) begin
         done0_cnt++;
         done0_rel      = cyc - acc0 + 1;
         ready_at_done0 = bus0.o_req_ready;
      end
   end

   // monitor for the GAP=3 instance: commands, idle runs, stall stability
   logic [7:0] q3[$];
   int         idle3[$];
   int         idle_run3 = 0;
   int         done3_cnt = 0;
   int         stab_obs  = 0;
   int         stab_viol = 0;
   logic       wait3 = 1'b0;
   logic [7:0] wait3_cmd = 8'h0;
   always @(negedge clk) begin
      if (rst) begin
         wait3 = 1'b0;
      end else begin
         if (wait3) begin
            stab_obs++;
            if (!(bus3.o_valid && bus3.o_cmd == wait3_cmd)) begin
               stab_viol++;
               $display("stall broken: valid=%0b cmd=%0h held=%0h", bus3.o_valid, bus3.o_cmd, wait3_cmd);
            end
         end
         if (!bus3.o_valid) idle_run3++;
         if (bus3.o_valid && bus3.i_cmd_ready) begin
            q3.push_back(bus3.o_cmd);
            idle3.push_back(idle_run3);
            idle_run3 = 0;
         end
         if (bus3.o_done) done3_cnt++;
         wait3     = bus3.o_valid && !bus3.i_cmd_ready;
         wait3_cmd = bus3.o_cmd;
      end
   end

   initial begin
      bus3.i_cmd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus3.i_cmd_ready = rnd3 ? ($urandom_range(0, 3) == 0) : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_req(input int sel, input logic [63:0] data);
      logic got;
      @(posedge clk);
      #1;
      if (sel == 0) begin
         bus0.i_req_valid = 1'b1;
         bus0.i_req_data  = data;
      end else begin
         bus3.i_req_valid = 1'b1;
         bus3.i_req_data  = data;
      end
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (sel == 0 ? bus0.o_req_ready : bus3.o_req_ready) begin
            got = 1'b1;
            if (sel == 0) acc0 = cyc + 1;
         end
      end
      chk("req_accept", got, 1'b1);
      @(posedge clk);
      #1;
      if (sel == 0) bus0.i_req_valid = 1'b0;
      else          bus3.i_req_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 600 && !got; k++) begin
         @(negedge clk);
         if (sel == 0 ? bus0.o_done : bus3.o_done) got = 1'b1;
      end
      chk("done_seen", got, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (sel == 0 ? bus0.o_req_ready : bus3.o_req_ready) got = 1'b1;
      end
      chk("ready_return", got, 1'b1);
   endtask

   typedef struct {
      logic [63:0]     data;
      int              n;
      logic [5:0][7:0] c;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int   base;
      int   dbase;
      logic got;
      logic [63:0] fa;

      vecs[0] = '{64'h0,                  1, 48'h0};
      vecs[1] = '{64'h8000_0000_0000_0005, 4, {16'h0, 8'h00, 8'hFF, 8'hC2, 8'hC0}};
      vecs[2] = '{64'h8000_0000_0000_0005, 1, 48'h0};
      vecs[3] = '{64'h1,                  3, {24'h0, 8'h00, 8'hBF, 8'h82}};
      vecs[4] = '{64'hF0,                 6, {8'h00, 8'hC7, 8'hC6, 8'hC5, 8'hC4, 8'h80}};

      bus0.i_req_valid = 1'b0;
      bus0.i_req_data  = '0;
      bus0.i_cmd_ready = 1'b1;
      bus3.i_req_valid = 1'b0;
      bus3.i_req_data  = '0;

      #2 rst = 1'b1;
      #2;
      chk("reset_outputs", {bus0.o_req_ready, bus0.o_valid, bus0.o_cmd, bus0.o_busy, bus0.o_done}, 12'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ready_after_reset", bus0.o_req_ready, 1'b1);

`ifdef X_BYTE_SEQ_FULL_WRITE_EN
      fa   = 64'hA;
      base = q0.size();
      do_req(0, fa);
      chk("full_count", q0.size() - base, 65);
      for (int j = 0; j < 64; j++) begin
         if (q0.size() > base + j) chk($sformatf("full_cmd%0d", j), q0[base + j], {1'b1, fa[j], 6'(j)});
      end
      if (q0.size() > base + 64) chk("full_apply", q0[base + 64], 8'h00);
`else
      fa = 64'h0;
      for (int i = 0; i < 5; i++) begin
         base  = q0.size();
         dbase = done0_cnt;
         do_req(0, vecs[i].data);
         chk($sformatf("v%0d_count", i), q0.size() - base, vecs[i].n);
         for (int j = 0; j < vecs[i].n; j++) begin
            if (q0.size() > base + j) chk($sformatf("v%0d_cmd%0d", i, j), q0[base + j], vecs[i].c[j]);
         end
         chk($sformatf("v%0d_done_once", i), done0_cnt - dbase, 1);
         if (i == 0) begin
            if (q0_rel.size() > base) chk("lat_apply_cycle", q0_rel[base], 65);
            chk("lat_done_cycle", done0_rel, 66);
            chk("lat_ready_at_done", ready_at_done0, 1'b1);
         end
      end

      // GAP=3 with a stalling consumer
      rnd3 = 1'b1;
      base = q3.size();
      do_req(1, 64'hC000_0000_0000_0001);
      chk("g3a_count", q3.size() - base, 4);
      if (q3.size() >= base + 4) begin
         chk("g3a_cmd0", q3[base],     8'hC0);
         chk("g3a_cmd1", q3[base + 1], 8'hFE);
         chk("g3a_cmd2", q3[base + 2], 8'hFF);
         chk("g3a_cmd3", q3[base + 3], 8'h00);
         chk("g3a_idle1", idle3[base + 1], 65);
         chk("g3a_idle2", idle3[base + 2], 4);
         chk("g3a_idle3", idle3[base + 3], 3);
      end
      base = q3.size();
      do_req(1, 64'h1);
      chk("g3b_count", q3.size() - base, 3);
      if (q3.size() >= base + 3) begin
         chk("g3b_cmd0", q3[base],     8'hBE);
         chk("g3b_cmd1", q3[base + 1], 8'hBF);
         chk("g3b_cmd2", q3[base + 2], 8'h00);
         chk("g3b_idle1", idle3[base + 1], 4);
         chk("g3b_idle2", idle3[base + 2], 3);
      end
      chk("g3_done_count", done3_cnt, 2);
      chk("g3_stall_seen", stab_obs > 0, 1'b1);
      chk("g3_stall_stable", stab_viol, 0);
      rnd3 = 1'b0;

      // reset during the second write of 64'hF (shadow holds 64'hF0 here)
      @(posedge clk);
      #1;
      bus0.i_req_valid = 1'b1;
      bus0.i_req_data  = 64'hF;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (bus0.o_req_ready) got = 1'b1;
      end
      chk("rst_req_accept", got, 1'b1);
      @(posedge clk);
      #1 bus0.i_req_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (bus0.o_valid && bus0.o_cmd == 8'hC1) got = 1'b1;
      end
      chk("rst_second_write_seen", got, 1'b1);
      chk("rst_busy_before", bus0.o_busy, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rst_valid_drop", bus0.o_valid, 1'b0);
      chk("rst_busy_drop", bus0.o_busy, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready_after", bus0.o_req_ready, 1'b1);
      base = q0.size();
      do_req(0, 64'hF);
      chk("rst_rereq_count", q0.size() - base, 5);
      for (int j = 0; j < 4; j++) begin
         if (q0.size() > base + j) chk($sformatf("rst_rereq_cmd%0d", j), q0[base + j], 8'hC0 + 8'(j));
      end
      if (q0.size() > base + 4) chk("rst_rereq_apply", q0[base + 4], 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
